// File: rtl/pkg.sv
// Shared FIFO configuration constants used by the write-side pointer logic.
package pkg;

  // log2 of the FIFO depth used when a block does not override it.
  localparam int FIFO_ADDR_WIDTH = 9;

endpackage

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full/occupancy control for an asynchronous FIFO.
// Keeps the binary and Gray write pointers, synchronizes the Gray read pointer
// through two flops, and produces full, occupancy and a sticky overflow flag.
// Optional feature: define WPTR_AFULL_EN to build the registered almost-full
// flag; without it f_afull is a constant 0 and no threshold logic exists.
module wptr_full_ctrl
  import pkg::*;
#(
  parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
  parameter int AFULL_THRESH = (2**ADDR_WIDTH) - 4
) (
  input  logic                  w_clk,
  input  logic                  wrst,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  f_full,
  output logic                  f_afull,
  output logic [ADDR_WIDTH:0]   w_count,
  output logic                  w_ovf
);

  localparam int PW = ADDR_WIDTH + 1;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to Gray conversion of a pointer value.
  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ {1'b0, b[PW-1:1]};
  endfunction

  // Registered state
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] wptr_gray_r;
  logic [PW-1:0] rsync1_r;
  logic [PW-1:0] rsync2_r;
  logic          f_full_r;
  logic [PW-1:0] w_count_r;
  logic          w_ovf_r;

  // Next-state values
  logic          accept_s;
  logic          drop_s;
  logic [PW-1:0] wbin_next_s;
  logic [PW-1:0] wgray_next_s;
  logic [PW-1:0] rgray_full_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] wcount_next_s;
  logic          wfull_next_s;
  logic          wovf_next_s;

  // Next pointer, full test against the synchronized read pointer, occupancy.
  always_comb begin
    accept_s      = w_en & ~f_full_r;
    drop_s        = w_en & f_full_r;
    wbin_next_s   = wptr_r + {{ADDR_WIDTH{1'b0}}, accept_s};
    wgray_next_s  = bin2gray(wbin_next_s);
    // Full means the writer is exactly one lap ahead: the top two Gray bits
    // differ from the reader's and the rest match.
    rgray_full_s  = {~rsync2_r[ADDR_WIDTH:ADDR_WIDTH-1], rsync2_r[ADDR_WIDTH-2:0]};
    wfull_next_s  = (wgray_next_s == rgray_full_s);
    rbin_s        = gray2bin(rsync2_r);
    wcount_next_s = wbin_next_s - rbin_s;
    wovf_next_s   = w_ovf_r | drop_s;
  end

  // Two-flop synchronizer for the read-domain Gray pointer.
  always_ff @(posedge w_clk or negedge wrst) begin
    if (!wrst) begin
      rsync1_r <= {PW{1'b0}};
      rsync2_r <= {PW{1'b0}};
    end else begin
      rsync1_r <= rptr_gray;
      rsync2_r <= rsync1_r;
    end
  end

  // Write pointers, full, occupancy and sticky overflow, all updated together.
  always_ff @(posedge w_clk or negedge wrst) begin
    if (!wrst) begin
      wptr_r      <= {PW{1'b0}};
      wptr_gray_r <= {PW{1'b0}};
      f_full_r    <= 1'b0;
      w_count_r   <= {PW{1'b0}};
      w_ovf_r     <= 1'b0;
    end else begin
      wptr_r      <= wbin_next_s;
      wptr_gray_r <= wgray_next_s;
      f_full_r    <= wfull_next_s;
      w_count_r   <= wcount_next_s;
      w_ovf_r     <= wovf_next_s;
    end
  end

`ifdef WPTR_AFULL_EN
  localparam logic [PW-1:0] AFULL_LEVEL = PW'(AFULL_THRESH);

  logic f_afull_r;
  logic afull_next_s;

  // Almost-full uses the same occupancy value that feeds w_count.
  always_comb begin
    afull_next_s = (wcount_next_s >= AFULL_LEVEL);
  end

  // Almost-full register, updated on the same edge as w_count.
  always_ff @(posedge w_clk or negedge wrst) begin
    if (!wrst) begin
      f_afull_r <= 1'b0;
    end else begin
      f_afull_r <= afull_next_s;
    end
  end

  assign f_afull = f_afull_r;
`else
  // Threshold is accepted but has no effect in this build; the port is constant.
  localparam logic AFULL_TIE = (AFULL_THRESH >= 0) ? 1'b0 : 1'b0;

  assign f_afull = AFULL_TIE;
`endif

  assign wptr      = wptr_r;
  assign wptr_gray = wptr_gray_r;
  assign f_full    = f_full_r;
  assign w_count   = w_count_r;
  assign w_ovf     = w_ovf_r;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl at ADDR_WIDTH=9, AFULL_THRESH=508.
module tb_wptr_full_ctrl;

  localparam int AW     = 9;
  localparam int PW     = AW + 1;
  localparam int DEPTH  = 512;
  localparam int THRESH = 508;
`ifdef WPTR_AFULL_EN
  localparam logic AFULL_EXP = 1'b1;
`else
  localparam logic AFULL_EXP = 1'b0;
`endif

  logic          w_clk = 1'b0;
  logic          wrst;
  logic          w_en;
  logic [PW-1:0] rptr_gray;
  logic [PW-1:0] wptr;
  logic [PW-1:0] wptr_gray;
  logic          f_full;
  logic          f_afull;
  logic [PW-1:0] w_count;
  logic          w_ovf;

  always #5 w_clk = ~w_clk;

  wptr_full_ctrl #(
    .ADDR_WIDTH  (AW),
    .AFULL_THRESH(THRESH)
  ) dut (
    .w_clk    (w_clk),
    .wrst     (wrst),
    .w_en     (w_en),
    .rptr_gray(rptr_gray),
    .wptr     (wptr),
    .wptr_gray(wptr_gray),
    .f_full   (f_full),
    .f_afull  (f_afull),
    .w_count  (w_count),
    .w_ovf    (w_ovf)
  );

  typedef struct packed {
    logic [PW-1:0] wptr;
    logic [PW-1:0] gray;
    logic          full;
    logic          afull;
    logic [PW-1:0] count;
    logic          ovf;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [PW-1:0] m_w;
  logic [PW-1:0] m_s1;
  logic [PW-1:0] m_s2;
  logic          m_full;
  logic          m_ovf;

  // Previously observed outputs, for edge-to-edge properties
  logic [PW-1:0] prev_gray;
  logic [PW-1:0] prev_wptr;
  logic          prev_full;
  logic          saw_wrap;
  logic          any_full;

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    for (int k = 0; k < PW; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_w       = '0;
    m_s1      = '0;
    m_s2      = '0;
    m_full    = 1'b0;
    m_ovf     = 1'b0;
    prev_gray = '0;
    prev_wptr = '0;
    prev_full = 1'b0;
    sb_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wptr"},  wptr,      32'h0);
    chk({tag, "_gray"},  wptr_gray, 32'h0);
    chk({tag, "_full"},  f_full,    32'h0);
    chk({tag, "_afull"}, f_afull,   32'h0);
    chk({tag, "_count"}, w_count,   32'h0);
    chk({tag, "_ovf"},   w_ovf,     32'h0);
  endtask

  // Drive one cycle, predict the result, then compare after the edge.
  task automatic step(input logic en, input logic [PW-1:0] rg);
    exp_t          e;
    logic          acc;
    logic [PW-1:0] nw;
    logic [PW-1:0] occ;
    w_en      = en;
    rptr_gray = rg;
    acc     = en && !m_full;
    nw      = m_w + (acc ? 10'd1 : 10'd0);
    occ     = nw - g2b(m_s2);
    e.wptr  = nw;
    e.gray  = b2g(nw);
    e.count = occ;
    e.full  = (occ == 10'(DEPTH));
    e.afull = AFULL_EXP && (occ >= 10'(THRESH));
    e.ovf   = m_ovf | (en & m_full);
    sb_q.push_back(e);
    m_w    = nw;
    m_full = e.full;
    m_ovf  = e.ovf;
    m_s2   = m_s1;
    m_s1   = rg;
    @(posedge w_clk);
    #1;
    e = sb_q.pop_front();
    chk("wptr",    wptr,      e.wptr);
    chk("gray",    wptr_gray, e.gray);
    chk("full",    f_full,    e.full);
    chk("afull",   f_afull,   e.afull);
    chk("count",   w_count,   e.count);
    chk("ovf",     w_ovf,     e.ovf);
    chk("gray_one_bit", ($countones(wptr_gray ^ prev_gray) <= 1), 32'h1);
    chk("no_write_while_full", (prev_full && (wptr != prev_wptr)), 32'h0);
    if (prev_wptr == 10'h3FF && wptr == 10'h000 && prev_gray == 10'h200 && wptr_gray == 10'h000)
      saw_wrap = 1'b1;
    any_full  = any_full | f_full;
    prev_gray = wptr_gray;
    prev_wptr = wptr;
    prev_full = f_full;
  endtask

  task automatic clean_reset();
    wrst = 1'b0;
    w_en = 1'b0;
    #1;
    model_reset();
    @(posedge w_clk);
    #1;
    wrst = 1'b1;
  endtask

  initial begin
    logic [PW-1:0] rd;
    logic          en;
    wrst      = 1'b0;
    w_en      = 1'b0;
    rptr_gray = '0;
    saw_wrap  = 1'b0;
    any_full  = 1'b0;
    model_reset();
    repeat (2) @(posedge w_clk);
    #1;
    chk_all_zero("reset");
    wrst = 1'b1;

    // First accept on the first edge after release
    step(1'b1, 10'h000);
    chk("first_accept", wptr, 32'h001);
    repeat (5) step(1'b1, 10'h000);

    // Reset asserted mid-cycle while writing
    #2;
    wrst = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    model_reset();
    @(posedge w_clk);
    #1;
    chk("reset_hold_wptr", wptr, 32'h0);
    wrst = 1'b1;
    step(1'b1, 10'h000);
    chk("restart_wptr", wptr, 32'h001);

    // Fill to 512 with the reader parked at 0
    for (int i = 0; i < 511; i++) begin
      step(1'b1, 10'h000);
      if (i == 505) chk("afull_below", f_afull, 32'h0);
      if (i == 506) chk("afull_at_508", f_afull, AFULL_EXP);
    end
    chk("fill_full",  f_full,    32'h1);
    chk("fill_wptr",  wptr,      32'h200);
    chk("fill_gray",  wptr_gray, 32'h300);
    chk("fill_count", w_count,   32'd512);
    chk("fill_ovf",   w_ovf,     32'h0);
    step(1'b1, 10'h000);
    chk("drop_wptr", wptr,  32'h200);
    chk("drop_ovf",  w_ovf, 32'h1);

    // Reader advances by one: full drops on the third edge
    step(1'b0, 10'h001);
    chk("drain_e1_full", f_full, 32'h1);
    step(1'b0, 10'h001);
    chk("drain_e2_full", f_full, 32'h1);
    step(1'b0, 10'h001);
    chk("drain_e3_full",  f_full,  32'h0);
    chk("drain_e3_count", w_count, 32'd511);
    step(1'b1, 10'h001);
    chk("refill_full", f_full, 32'h1);
    chk("refill_wptr", wptr,   32'h201);
    chk("ovf_sticky",  w_ovf,  32'h1);

    // Reader tracks the writer through 1100 writes and a pointer wrap
    clean_reset();
    saw_wrap = 1'b0;
    any_full = 1'b0;
    for (int i = 0; i < 1100; i++) step(1'b1, b2g(m_w));
    chk("track_wrap_seen", saw_wrap, 32'h1);
    chk("track_never_full", any_full, 32'h0);
    chk("track_ovf", w_ovf, 32'h0);
    chk("track_wptr", wptr, 32'd76);

    // Random writer against a random legal Gray read stream
    clean_reset();
    rd = '0;
    for (int i = 0; i < 1500; i++) begin
      en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0 && rd != m_w) rd = rd + 10'd1;
      step(en, b2g(rd));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
